// File: rtl/tpg_pkg.sv
// Shared types and defaults for the test-pattern timing controller:
// pattern/state encodings, 720p default timing and the colour-bar table.
package tpg_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pattern_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DRAIN
   } tpg_state_t;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_H_FP     = 110;
   localparam int DEF_H_SYNC   = 40;
   localparam int DEF_H_BP     = 220;
   localparam int DEF_V_ACTIVE = 720;
   localparam int DEF_V_FP     = 5;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 20;
   localparam int DEF_SYNC_POL = 1;
   localparam int DEF_CNT_W    = 12;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int BAR_W   = DEF_H_ACTIVE / 8;

   // W, Y, C, G, M, R, B, K
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with wrap flags and raw sync/DE decode
// of the current counter position (unregistered; the top registers them).
module video_timing_counter
   import tpg_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CNT_W    = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             h_last,
   output logic             frame_last,
   output logic             hsync_on,
   output logic             vsync_on,
   output logic             de_on
);

   localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] H_DE   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] V_DE   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic v_last;

   assign h_last     = (h_cnt == H_END);
   assign v_last     = (v_cnt == V_END);
   assign frame_last = h_last && v_last;
   assign hsync_on   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   // v_cnt only moves on the h wrap, so vsync can only change at h_cnt=0
   assign vsync_on   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign de_on      = (h_cnt < H_DE) && (v_cnt < V_DE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tpg_timing_ctrl.sv
// Video timing and test-pattern generator: run/stop FSM, frame-boundary config
// latch, pattern generator and the registered hsync/vsync/DE/pixel outputs.
module tpg_timing_ctrl
   import tpg_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = DEF_SYNC_POL,
   parameter int CNT_W    = DEF_CNT_W
)(
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_color,
   output logic        busy,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [23:0] vdata
);

   localparam logic             SYNC_ON = (SYNC_POL != 0);
   localparam logic [CNT_W-1:0] BAR_END = CNT_W'(H_ACTIVE / 8 - 1);

   tpg_state_t       state, nxt;
   logic             latch_cfg;
   logic             run;
   pattern_t         pat_q;
   logic [23:0]      solid_q;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_last, frame_last, hsync_on, vsync_on, de_on;
   logic [CNT_W-1:0] bar_px;
   logic [2:0]       bar_idx;
   logic [23:0]      pix;

   assign run = (state == ST_RUN) || (state == ST_DRAIN);

   video_timing_counter #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .CNT_W    (CNT_W)
   ) u_timing (
      .clk        (CLK),
      .rst_n      (RSTn),
      .run        (run),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .h_last     (h_last),
      .frame_last (frame_last),
      .hsync_on   (hsync_on),
      .vsync_on   (vsync_on),
      .de_on      (de_on)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= ST_IDLE;
      else       state <= nxt;
   end

   // Stop and pattern changes only resolve on the last pixel of a frame
   always_comb begin
      nxt       = state;
      latch_cfg = 1'b0;
      case (state)
         ST_IDLE:  if (enable) nxt = ST_ARM;
         ST_ARM: begin
            latch_cfg = 1'b1;
            nxt       = ST_RUN;
         end
         ST_RUN: begin
            latch_cfg = frame_last;
            if (!enable) nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            latch_cfg = frame_last;
            if (enable)          nxt = ST_RUN;
            else if (frame_last) nxt = ST_IDLE;
         end
         default:  nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (latch_cfg) begin
         pat_q   <= pattern_t'(pattern_sel);
         solid_q <= solid_color;
      end
   end

   // Bar position tracks h_cnt by counting pixels per bar instead of dividing
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (!run || h_last) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bar_px == BAR_END) begin
         bar_px  <= '0;
         bar_idx <= bar_idx + 1'b1;
      end else begin
         bar_px  <= bar_px + 1'b1;
      end
   end

   always_comb begin
      pix = '0;
      case (pat_q)
         PAT_BARS:  pix = bar_color(bar_idx);
         PAT_RAMP:  pix = {3{h_cnt[7:0]}};
         PAT_CHECK: pix = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
         default:   pix = solid_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         busy        <= 1'b0;
         frame_start <= 1'b0;
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         de          <= 1'b0;
         vdata       <= '0;
      end else begin
         busy <= (nxt != ST_IDLE);
         if (run) begin
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            hsync       <= hsync_on ? SYNC_ON : ~SYNC_ON;
            vsync       <= vsync_on ? SYNC_ON : ~SYNC_ON;
            de          <= de_on;
            vdata       <= de_on ? pix : '0;
         end else begin
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            vdata       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Bench for tpg_timing_ctrl on a reduced 22x7 raster: per-cycle comparison
// against a frame-position reference model plus directed start/stop checks.
module tb_tpg_timing_ctrl;

   localparam int HT = 22;
   localparam int FT = 154;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_color;
   logic        busy, frame_start, hsync, vsync, de;
   logic [23:0] vdata;

   tpg_timing_ctrl #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1),  .CNT_W (12)
   ) dut (
      .CLK         (clk),
      .RSTn        (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .solid_color (solid_color),
      .busy        (busy),
      .frame_start (frame_start),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .vdata       (vdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [23:0] bar_tab [8];

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [23:0] model_pix(input int x, input int y,
                                             input logic [1:0] ps, input logic [23:0] sc);
      case (ps)
         2'd0:    return bar_tab[x / 2];
         2'd1:    return 24'((x % 256) * 'h010101);
         2'd2:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
         default: return sc;
      endcase
   endfunction

   // Reference: ph 0 idle, 1 arm, 2 run, 3 drain; p is the linear pixel index in the frame
   int          ph = 0;
   int          p  = 0;
   int          mx, my;
   bit          mlast;
   logic [1:0]  m_ps;
   logic [23:0] m_sc;
   logic        e_busy, e_fs, e_hs, e_vs, e_de;
   logic [23:0] e_vd;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         ph = 0; p = 0;
         e_busy = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_de = 0; e_vd = '0;
      end else begin
         if (ph >= 2) begin
            mx   = p % HT;
            my   = p / HT;
            e_de = (mx < 16) && (my < 4);
            e_hs = (mx >= 18) && (mx < 20);
            e_vs = (my == 5);
            e_fs = (p == 0);
            e_vd = e_de ? model_pix(mx, my, m_ps, m_sc) : 24'h0;
         end else begin
            e_fs = 0; e_hs = 0; e_vs = 0; e_de = 0; e_vd = '0;
         end
         case (ph)
            0: if (enable) ph = 1;
            1: begin
               m_ps = pattern_sel;
               m_sc = solid_color;
               ph   = 2;
            end
            default: begin
               mlast = (p == FT - 1);
               if (mlast) begin
                  m_ps = pattern_sel;
                  m_sc = solid_color;
               end
               p = (p + 1) % FT;
               if (ph == 2) begin
                  if (!enable) ph = 3;
               end else begin
                  if (enable)     ph = 2;
                  else if (mlast) ph = 0;
               end
            end
         endcase
         e_busy = (ph != 0);
      end
      #1;
      chk_val("m_busy",  32'(busy),        32'(e_busy));
      chk_val("m_fs",    32'(frame_start), 32'(e_fs));
      chk_val("m_hsync", 32'(hsync),       32'(e_hs));
      chk_val("m_vsync", 32'(vsync),       32'(e_vs));
      chk_val("m_de",    32'(de),          32'(e_de));
      chk_val("m_vdata", 32'(vdata),       32'(e_vd));
   end

   task automatic wait_fs(output int at);
      bit seen = 0;
      at = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            seen = 1;
            at   = cyc;
         end
      end
      chk_val("fs_wait", 32'(seen), 32'd1);
   endtask

   task automatic wait_busy_low(output int at);
      bit seen = 0;
      at = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            seen = 1;
            at   = cyc;
         end
      end
      chk_val("busy_wait", 32'(seen), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk_val({tag, "_busy"},  32'(busy),        32'd0);
      chk_val({tag, "_fs"},    32'(frame_start), 32'd0);
      chk_val({tag, "_hsync"}, 32'(hsync),       32'd0);
      chk_val({tag, "_vsync"}, 32'(vsync),       32'd0);
      chk_val({tag, "_de"},    32'(de),          32'd0);
      chk_val({tag, "_vdata"}, 32'(vdata),       32'd0);
   endtask

   initial begin
      int f0, f1, f2, b;
      bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      rst_n       = 1'b0;
      enable      = 1'b1;
      pattern_sel = 2'd0;
      solid_color = 24'h0;
      repeat (4) @(negedge clk);
      chk_idle("rst");
      rst_n  = 1'b1;
      enable = 1'b0;
      repeat (10) @(negedge clk);
      chk_idle("post_rst");

      // start latency
      enable = 1'b1;
      @(negedge clk);
      chk_val("start_busy", 32'(busy), 32'd1);
      chk_val("start_de0",  32'(de),   32'd0);
      @(negedge clk);
      chk_val("start_fs0",  32'(frame_start), 32'd0);
      @(negedge clk);
      chk_val("start_fs1",  32'(frame_start), 32'd1);
      chk_val("start_de1",  32'(de),          32'd1);
      f0 = cyc;
      for (int j = 0; j < 16; j++) begin
         chk_val("bar", 32'(vdata), 32'(bar_tab[j / 2]));
         if (j == 1) chk_val("fs_width", 32'(frame_start), 32'd0);
         @(negedge clk);
      end
      chk_val("de_end", 32'(de), 32'd0);
      repeat (2) @(negedge clk);
      chk_val("hs_on0", 32'(hsync), 32'd1);
      @(negedge clk);
      chk_val("hs_on1", 32'(hsync), 32'd1);
      @(negedge clk);
      chk_val("hs_off", 32'(hsync), 32'd0);

      // pattern change mid-frame
      wait_fs(f1);
      chk_val("fs_period", f1 - f0, FT);
      chk_val("bars_px0",  32'(vdata), 32'hFFFFFF);
      repeat (44) @(negedge clk);
      pattern_sel = 2'd3;
      solid_color = 24'h123456;
      repeat (30) @(negedge clk);
      chk_val("keep_bars", 32'(vdata), 32'(bar_tab[4]));
      wait_fs(f2);
      chk_val("fs_period2", f2 - f1, FT);
      chk_val("solid_px0",  32'(vdata), 32'h123456);

      // reset in the middle of a frame
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // stop at line 1: frame completes, then idle
      wait_fs(f0);
      repeat (22) @(negedge clk);
      enable = 1'b0;
      wait_busy_low(b);
      chk_val("busy_fall", b - f0, FT - 1);
      repeat (5) @(negedge clk);
      chk_idle("stopped");

      // re-enable during drain keeps frame cadence
      enable = 1'b1;
      wait_fs(f1);
      repeat (22) @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      chk_val("drain_busy", 32'(busy), 32'd1);
      enable = 1'b1;
      wait_fs(f2);
      chk_val("restart_period", f2 - f1, FT);

      // random enable / config traffic
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         if ($urandom_range(0, 39) == 0)  pattern_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0)  solid_color = 24'($urandom);
      end
      enable = 1'b0;
      repeat (400) @(negedge clk);
      chk_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
